// File: rtl/dma_pkg.sv
// Shared types for the Venus DMA: descriptor, error and status records,
// plus the descriptor-sequencer state encoding.
package dma_pkg;

  localparam int DMA_NUM_DESC = 2;

  typedef enum logic [1:0] {
    DMA_ERR_NONE   = 2'd0,
    DMA_AXI_RD_ERR = 2'd1,
    DMA_AXI_WR_ERR = 2'd2,
    DMA_DESC_ERR   = 2'd3
  } dma_err_src_t;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [15:0] num_bytes;
    logic [31:0] dst_addr;
  } s_dma_desc_t;

  typedef struct packed {
    logic         valid;
    logic [31:0]  addr;
    dma_err_src_t src;
  } s_dma_error_t;

  typedef struct packed {
    logic error;
    logic done;
    logic active;
  } s_dma_status_t;

  typedef enum logic [1:0] {
    SCH_IDLE  = 2'd0,
    SCH_ISSUE = 2'd1,
    SCH_WAIT  = 2'd2,
    SCH_DONE  = 2'd3
  } dma_sched_st_t;

endpackage

// File: rtl/dma_desc_pick.sv
// Find-first eligible slot at or above start_i; start_i may equal NUM_DESC,
// which simply yields found_o=0.
module dma_desc_pick
  import dma_pkg::*;
#(
  parameter int NUM_DESC = DMA_NUM_DESC,
  parameter int IDX_W    = $clog2(NUM_DESC > 1 ? NUM_DESC : 2)
) (
  input  logic [NUM_DESC-1:0] elig_i,
  input  logic [IDX_W:0]      start_i,
  output logic                found_o,
  output logic [IDX_W-1:0]    idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = NUM_DESC - 1; i >= 0; i--) begin
      if (elig_i[i] && (i >= int'(start_i))) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/dma_desc_sched.sv
// Descriptor sequencer: walks enabled, non-empty slots in index order and
// hands them one at a time to the streamer, aggregating status for CSR.
//   state     | meaning
//   SCH_IDLE  | no run since reset
//   SCH_ISSUE | descriptor offered, waiting for strm_ready_i
//   SCH_WAIT  | descriptor accepted, waiting for done/error
//   SCH_DONE  | run finished, status.done sticky until next go
module dma_desc_sched
  import dma_pkg::*;
#(
  parameter int NUM_DESC = DMA_NUM_DESC,
  parameter int IDX_W    = $clog2(NUM_DESC > 1 ? NUM_DESC : 2)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_go_i,
  input  logic                cfg_abort_i,
  input  s_dma_desc_t         desc_i [NUM_DESC],
  input  logic [NUM_DESC-1:0] desc_en_i,
  output s_dma_desc_t         strm_desc_o,
  output logic                strm_valid_o,
  input  logic                strm_ready_i,
  input  logic                strm_done_i,
  input  s_dma_error_t        strm_err_i,
  output s_dma_status_t       status_o,
  output s_dma_error_t        error_o,
  output logic [IDX_W-1:0]    cur_idx_o,
  output logic                irq_o
);

  dma_sched_st_t       state_q, state_d;
  logic [NUM_DESC-1:0] en_q, en_d;
  s_dma_desc_t         desc_q, desc_d;
  logic                valid_q, valid_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  s_dma_status_t       status_q, status_d;
  s_dma_error_t        error_q, error_d;
  logic                irq_q, irq_d;

  logic [NUM_DESC-1:0] nz;
  logic [NUM_DESC-1:0] pick_elig;
  logic [IDX_W:0]      pick_start;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic                idle;

  always_comb begin
    for (int i = 0; i < NUM_DESC; i++) begin
      nz[i] = (desc_i[i].num_bytes != '0);
    end
  end

  // While idle the pick looks at the live enables (the snapshot is being taken
  // this cycle); mid-run it searches the snapshot above the current slot.
  assign idle       = (state_q == SCH_IDLE) || (state_q == SCH_DONE);
  assign pick_elig  = idle ? (desc_en_i & nz) : (en_q & nz);
  assign pick_start = idle ? '0 : ({1'b0, idx_q} + (IDX_W+1)'(1));

  dma_desc_pick #(
    .NUM_DESC (NUM_DESC),
    .IDX_W    (IDX_W)
  ) u_pick (
    .elig_i  (pick_elig),
    .start_i (pick_start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    desc_d   = desc_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    status_d = status_q;
    error_d  = error_q;
    irq_d    = 1'b0;

    case (state_q)
      SCH_IDLE, SCH_DONE: begin
        if (cfg_go_i) begin
          en_d            = desc_en_i;
          status_d.done   = 1'b0;
          status_d.error  = 1'b0;
          error_d         = '0;
          if (pick_found) begin
            state_d = SCH_ISSUE;
            idx_d   = pick_idx;
            desc_d  = desc_i[pick_idx];
            valid_d = 1'b1;
          end else begin
            state_d       = SCH_DONE;
            status_d.done = 1'b1;
            irq_d         = 1'b1;
          end
        end
      end
      SCH_ISSUE: begin
        if (strm_ready_i) begin
          state_d = SCH_WAIT;
          valid_d = 1'b0;
        end else if (cfg_abort_i) begin
          state_d       = SCH_DONE;
          valid_d       = 1'b0;
          status_d.done = 1'b1;
          irq_d         = 1'b1;
        end
      end
      SCH_WAIT: begin
        if (strm_err_i.valid) begin
          if (!error_q.valid) begin
            error_d       = strm_err_i;
            error_d.valid = 1'b1;
          end
          status_d.error = 1'b1;
          status_d.done  = 1'b1;
          state_d        = SCH_DONE;
          irq_d          = 1'b1;
        end else if (strm_done_i) begin
          if (cfg_abort_i || !pick_found) begin
            state_d       = SCH_DONE;
            status_d.done = 1'b1;
            irq_d         = 1'b1;
          end else begin
            state_d = SCH_ISSUE;
            idx_d   = pick_idx;
            desc_d  = desc_i[pick_idx];
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = SCH_IDLE;
    endcase

    status_d.active = (state_d == SCH_ISSUE) || (state_d == SCH_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SCH_IDLE;
      en_q     <= '0;
      desc_q   <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      status_q <= '0;
      error_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      desc_q   <= desc_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      status_q <= status_d;
      error_q  <= error_d;
      irq_q    <= irq_d;
    end
  end

  assign strm_desc_o  = desc_q;
  assign strm_valid_o = valid_q;
  assign cur_idx_o    = idx_q;
  assign status_o     = status_q;
  assign error_o      = error_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_dma_desc_sched.sv
// Bench for dma_desc_sched: expected descriptors are queued when go is driven
// and popped when the bench completes a handshake with the sequencer.
module tb_dma_desc_sched;
  import dma_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic          ready = 1'b0;
  logic          done = 1'b0;
  s_dma_desc_t   desc [DMA_NUM_DESC];
  logic [1:0]    en = 2'b00;
  s_dma_error_t  err_in = '0;
  s_dma_desc_t   strm_desc_o;
  logic          strm_valid_o;
  s_dma_status_t status_o;
  s_dma_error_t  error_o;
  logic [0:0]    cur_idx_o;
  logic          irq_o;

  s_dma_desc_t   exp_desc_q [$];
  int            exp_idx_q [$];
  int            n_chk = 0;
  int            n_fail = 0;

  localparam s_dma_desc_t  D0  = '{src_addr: 32'h1000, num_bytes: 16'd256, dst_addr: 32'h2000};
  localparam s_dma_desc_t  D1  = '{src_addr: 32'h3000, num_bytes: 16'd64,  dst_addr: 32'h4000};
  localparam s_dma_desc_t  D1B = '{src_addr: 32'h3000, num_bytes: 16'd128, dst_addr: 32'h4000};
  localparam s_dma_desc_t  DZ  = '{src_addr: 32'h1000, num_bytes: 16'd0,   dst_addr: 32'h2000};
  localparam s_dma_error_t ERR = '{valid: 1'b1, addr: 32'h2040, src: DMA_AXI_WR_ERR};

  dma_desc_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_go_i     (go),
    .cfg_abort_i  (abort),
    .desc_i       (desc),
    .desc_en_i    (en),
    .strm_desc_o  (strm_desc_o),
    .strm_valid_o (strm_valid_o),
    .strm_ready_i (ready),
    .strm_done_i  (done),
    .strm_err_i   (err_in),
    .status_o     (status_o),
    .error_o      (error_o),
    .cur_idx_o    (cur_idx_o),
    .irq_o        (irq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic expect_issue(input s_dma_desc_t d, input int idx);
    exp_desc_q.push_back(d);
    exp_idx_q.push_back(idx);
  endtask

  // Completes the handshake on the currently offered descriptor.
  task automatic accept(input string tag);
    s_dma_desc_t ed;
    int          ei;
    check({tag, "_valid"}, strm_valid_o, 1'b1);
    if (exp_desc_q.size() == 0) begin
      check({tag, "_unexpected_issue"}, 1'b1, 1'b0);
    end else begin
      ed = exp_desc_q.pop_front();
      ei = exp_idx_q.pop_front();
      check({tag, "_desc"}, strm_desc_o, ed);
      check({tag, "_idx"}, cur_idx_o, ei[0:0]);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check({tag, "_valid_drop"}, strm_valid_o, 1'b0);
    check({tag, "_wait_status"}, status_o, 3'b001);
  endtask

  task automatic finish_desc();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    desc[0] = D0;
    desc[1] = D1;
    repeat (2) tick();
    check("rst_valid", strm_valid_o, 1'b0);
    check("rst_desc", strm_desc_o, '0);
    check("rst_status", status_o, 3'b000);
    check("rst_error", error_o, '0);
    check("rst_irq", irq_o, 1'b0);
    check("rst_idx", cur_idx_o, 1'b0);
    rst_n = 1'b1;
    tick();

    // two-slot run
    en = 2'b11;
    expect_issue(D0, 0);
    expect_issue(D1, 1);
    pulse_go();
    check("t1_valid_n1", strm_valid_o, 1'b1);
    check("t1_active", status_o, 3'b001);
    accept("t1_s0");
    repeat (3) tick();
    finish_desc();
    check("t1_next_valid_k1", strm_valid_o, 1'b1);
    accept("t1_s1");
    finish_desc();
    check("t1_irq", irq_o, 1'b1);
    check("t1_status", status_o, 3'b010);
    tick();
    check("t1_irq_pulse", irq_o, 1'b0);
    check("t1_done_sticky", status_o, 3'b010);
    check("t1_sb_empty", exp_desc_q.size(), 0);

    // zero-length slot 0 is skipped
    desc[0] = DZ;
    desc[1] = D1B;
    expect_issue(D1B, 1);
    pulse_go();
    accept("t2_s1");
    finish_desc();
    check("t2_irq", irq_o, 1'b1);
    check("t2_status", status_o, 3'b010);

    // nothing enabled
    en = 2'b00;
    pulse_go();
    check("t3_no_valid", strm_valid_o, 1'b0);
    check("t3_status", status_o, 3'b010);
    check("t3_irq", irq_o, 1'b1);
    tick();
    check("t3_irq_pulse", irq_o, 1'b0);
    err_in = ERR;
    tick();
    err_in = '0;
    tick();
    check("t3_err_outside_wait", error_o, '0);
    check("t3_status_no_err", status_o, 3'b010);

    // stalled ready and go pulses mid-run
    desc[0] = D0;
    desc[1] = D1;
    en = 2'b01;
    expect_issue(D0, 0);
    pulse_go();
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_desc", strm_desc_o, D0);
      check("t4_hold_valid", strm_valid_o, 1'b1);
      check("t4_hold_idx", cur_idx_o, 1'b0);
      go = (i == 2);
      tick();
      go = 1'b0;
    end
    accept("t4_s0");
    go = 1'b1;
    tick();
    go = 1'b0;
    check("t4_go_in_wait", status_o, 3'b001);
    check("t4_no_reissue", strm_valid_o, 1'b0);
    finish_desc();
    check("t4_irq", irq_o, 1'b1);
    check("t4_status", status_o, 3'b010);
    check("t4_sb_empty", exp_desc_q.size(), 0);

    // error coincident with done on slot 0
    en = 2'b11;
    expect_issue(D0, 0);
    pulse_go();
    accept("t5_s0");
    tick();
    err_in = ERR;
    done = 1'b1;
    tick();
    err_in = '0;
    done = 1'b0;
    check("t5_status", status_o, 3'b110);
    check("t5_error", error_o, ERR);
    check("t5_irq", irq_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("t5_no_issue", strm_valid_o, 1'b0);
      tick();
    end
    check("t5_sb_empty", exp_desc_q.size(), 0);
    en = 2'b00;
    pulse_go();
    check("t5_go_clears_error", error_o, '0);
    check("t5_go_clears_status", status_o, 3'b010);

    // abort during WAIT
    en = 2'b11;
    expect_issue(D0, 0);
    pulse_go();
    accept("t6_s0");
    abort = 1'b1;
    finish_desc();
    abort = 1'b0;
    check("t6_wait_abort_valid", strm_valid_o, 1'b0);
    check("t6_wait_abort_irq", irq_o, 1'b1);
    check("t6_wait_abort_status", status_o, 3'b010);
    tick();
    check("t6_wait_abort_no_issue", strm_valid_o, 1'b0);

    // abort during ISSUE with ready low
    pulse_go();
    check("t6_issue_valid", strm_valid_o, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_issue_abort_valid", strm_valid_o, 1'b0);
    check("t6_issue_abort_status", status_o, 3'b010);
    check("t6_issue_abort_irq", irq_o, 1'b1);

    // asynchronous reset mid-WAIT
    expect_issue(D0, 0);
    pulse_go();
    accept("t7_s0");
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_valid", strm_valid_o, 1'b0);
    check("t7_rst_desc", strm_desc_o, '0);
    check("t7_rst_status", status_o, 3'b000);
    check("t7_rst_error", error_o, '0);
    check("t7_rst_idx", cur_idx_o, 1'b0);
    check("t7_rst_irq", irq_o, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t7_post_rst_idle", status_o, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
